// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the core-side bus arbiter: FSM state encoding,
// SRAM-like transfer size codes and a small store-detect helper.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_ADDR = 3'd1,
        ST_D_DATA = 3'd2,
        ST_I_ADDR = 3'd3,
        ST_I_DATA = 3'd4
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    function automatic logic is_store(input logic [3:0] wen);
        return |wen;
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_wen_to_size.sv
// Byte-enable decoder: turns a store's lane mask into SRAM-like size and the
// low two address bits. Patterns that are not a legal aligned lane group fall
// back to a full word.
module wen_to_size
    import cpu_bus_pkg::*;
(
    input  logic [3:0] wen_i,
    output logic [1:0] size_o,
    output logic [1:0] addr_lo_o
);

    always_comb begin
        size_o    = SZ_WORD;
        addr_lo_o = 2'b00;
        case (wen_i)
            4'b1111: begin size_o = SZ_WORD; addr_lo_o = 2'b00; end
            4'b0011: begin size_o = SZ_HALF; addr_lo_o = 2'b00; end
            4'b1100: begin size_o = SZ_HALF; addr_lo_o = 2'b10; end
            4'b0001: begin size_o = SZ_BYTE; addr_lo_o = 2'b00; end
            4'b0010: begin size_o = SZ_BYTE; addr_lo_o = 2'b01; end
            4'b0100: begin size_o = SZ_BYTE; addr_lo_o = 2'b10; end
            4'b1000: begin size_o = SZ_BYTE; addr_lo_o = 2'b11; end
            default: begin size_o = SZ_WORD; addr_lo_o = 2'b00; end
        endcase
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one SRAM-like master port between instruction fetch and data access,
// one transaction at a time with data first, and holds results until the pipeline advances.
module cpu_mem_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_en,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              i_stall,

    input  logic              mem_en,
    input  logic              mem_rd,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              d_stall,

    input  logic              all_stall,

    // Handshake: bus_req with its fields is held from registered state until
    // bus_addr_ok is seen high at a clock edge; bus_data_ok then completes it.
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic [2:0]        dbg_state_o
);

    arb_state_e        state_q, state_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] ibuf_q, ibuf_d;
    logic [DATA_W-1:0] dbuf_q, dbuf_d;

    logic              d_is_store;
    logic              d_pend;
    logic              i_pend;
    logic [1:0]        st_size;
    logic [1:0]        st_addr_lo;

    wen_to_size u_wen_to_size (
        .wen_i     (mem_wen),
        .size_o    (st_size),
        .addr_lo_o (st_addr_lo)
    );

    assign d_is_store = is_store(mem_wen);
    assign d_pend     = mem_en & (mem_rd | d_is_store) & ~d_done_q;
    assign i_pend     = inst_en & ~i_done_q;

    assign d_stall     = d_pend;
    assign i_stall     = i_pend;
    assign mem_rdata   = dbuf_q;
    assign inst_rdata  = ibuf_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d   = state_q;
        i_done_d  = i_done_q;
        d_done_d  = d_done_q;
        ibuf_d    = ibuf_q;
        dbuf_d    = dbuf_q;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = SZ_WORD;
        bus_addr  = '0;
        bus_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (d_pend) begin
                    state_d = ST_D_ADDR;
                end else if (i_pend) begin
                    state_d = ST_I_ADDR;
                end
            end
            ST_D_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = d_is_store;
                bus_wdata = mem_wdata;
                if (d_is_store) begin
                    bus_size = st_size;
                    bus_addr = {mem_addr[ADDR_W-1:2], st_addr_lo};
                end else begin
                    bus_size = SZ_WORD;
                    bus_addr = mem_addr;
                end
                if (bus_addr_ok) begin
                    state_d = ST_D_DATA;
                end
            end
            ST_D_DATA: begin
                if (bus_data_ok) begin
                    dbuf_d   = bus_rdata;
                    d_done_d = 1'b1;
                    // Chain straight into a waiting fetch without an idle bubble.
                    state_d  = i_pend ? ST_I_ADDR : ST_IDLE;
                end
            end
            ST_I_ADDR: begin
                bus_req  = 1'b1;
                bus_wr   = 1'b0;
                bus_size = SZ_WORD;
                bus_addr = inst_addr;
                if (bus_addr_ok) begin
                    state_d = ST_I_DATA;
                end
            end
            ST_I_DATA: begin
                if (bus_data_ok) begin
                    ibuf_d   = bus_rdata;
                    i_done_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The pipeline advanced: both requesters move on to new work.
        if (!all_stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            ibuf_q   <= '0;
            dbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            ibuf_q   <= ibuf_d;
            dbuf_q   <= dbuf_d;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, one task per scenario.
module tb_cpu_mem_arbiter;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_D_ADDR = 3'd1;
    localparam logic [2:0] S_D_DATA = 3'd2;
    localparam logic [2:0] S_I_ADDR = 3'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        mem_en = 1'b0;
    logic        mem_rd = 1'b0;
    logic [3:0]  mem_wen = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        d_stall;
    logic        all_stall = 1'b0;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Store table: lane mask, required size, required low address bits.
    logic [3:0] st_wen [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0101};
    logic [1:0] st_sz  [8] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
    logic [1:0] st_lo  [8] = '{2'b00, 2'b00, 2'b10, 2'b00,
                               2'b01, 2'b10, 2'b11, 2'b00};

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_en     (inst_en),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .i_stall     (i_stall),
        .mem_en      (mem_en),
        .mem_rd      (mem_rd),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .d_stall     (d_stall),
        .all_stall   (all_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_en = 1'b0; mem_en = 1'b0; mem_rd = 1'b0; mem_wen = '0;
        all_stall = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle(); next_cycle();
        rst = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
        n_cmp++; if ({i_stall, d_stall} !== 2'b00) begin n_err++; $display("FAIL reset_stalls got=%b exp=00", {i_stall, d_stall}); end
        n_cmp++; if (inst_rdata !== 32'h0 || mem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_bufs got=%h/%h exp=0/0", inst_rdata, mem_rdata); end
        // A stray data_ok while idle must be ignored.
        bus_data_ok = 1'b1; bus_rdata = 32'hDEADBEEF;
        next_cycle();
        bus_data_ok = 1'b0;
        #1;
        n_cmp++; if (mem_rdata !== 32'h0 || inst_rdata !== 32'h0) begin n_err++; $display("FAIL stray_data_ok got=%h/%h exp=0/0", inst_rdata, mem_rdata); end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        inst_en = 1'b1; inst_addr = 32'hBFC00000; all_stall = 1'b1;
        #1;
        n_cmp++; if ({bus_req, i_stall} !== 2'b01) begin n_err++; $display("FAIL fetch_c0 got=%b exp=01", {bus_req, i_stall}); end
        next_cycle();
        bus_addr_ok = 1'b1;
        #1;
        n_cmp++; if ({bus_req, bus_wr, bus_size, i_stall} !== 5'b1_0_10_1) begin n_err++; $display("FAIL fetch_c1_ctl got=%b exp=101 01", {bus_req, bus_wr, bus_size, i_stall}); end
        n_cmp++; if (bus_addr !== 32'hBFC00000) begin n_err++; $display("FAIL fetch_c1_addr got=%h exp=bfc00000", bus_addr); end
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C08BFAF;
        #1;
        n_cmp++; if ({bus_req, i_stall} !== 2'b01) begin n_err++; $display("FAIL fetch_c2 got=%b exp=01", {bus_req, i_stall}); end
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = 32'h0;
        #1;
        n_cmp++; if (i_stall !== 1'b0) begin n_err++; $display("FAIL fetch_c3_stall got=%b exp=0", i_stall); end
        n_cmp++; if (inst_rdata !== 32'h3C08BFAF) begin n_err++; $display("FAIL fetch_c3_data got=%h exp=3c08bfaf", inst_rdata); end
        all_stall = 1'b0; inst_en = 1'b0;
        next_cycle();
        #1;
        n_cmp++; if ({bus_req, i_stall, inst_rdata} !== {2'b00, 32'h3C08BFAF}) begin n_err++; $display("FAIL fetch_c4 got=%b%b %h exp=00 3c08bfaf", bus_req, i_stall, inst_rdata); end
    endtask

    task automatic test_load_and_fetch();
        next_cycle();
        mem_en = 1'b1; mem_rd = 1'b1; mem_addr = 32'h80001000;
        inst_en = 1'b1; inst_addr = 32'hBFC00004; all_stall = 1'b1;
        #1;
        n_cmp++; if ({d_stall, i_stall} !== 2'b11) begin n_err++; $display("FAIL lf_c0_stalls got=%b exp=11", {d_stall, i_stall}); end
        next_cycle();
        bus_addr_ok = 1'b1;
        #1;
        n_cmp++; if ({bus_req, bus_wr, bus_addr} !== {2'b10, 32'h80001000}) begin n_err++; $display("FAIL lf_c1_data_first got=%b%b %h exp=10 80001000", bus_req, bus_wr, bus_addr); end
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
        #1;
        n_cmp++; if (dbg_state !== S_D_DATA || bus_req !== 1'b0) begin n_err++; $display("FAIL lf_c2 got=%0d/%b exp=%0d/0", dbg_state, bus_req, S_D_DATA); end
        next_cycle();
        bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
        #1;
        n_cmp++; if (dbg_state !== S_I_ADDR || bus_req !== 1'b1 || bus_addr !== 32'hBFC00004) begin n_err++; $display("FAIL lf_c3_fetch got=%0d/%b/%h exp=%0d/1/bfc00004", dbg_state, bus_req, bus_addr, S_I_ADDR); end
        n_cmp++; if ({d_stall, i_stall} !== 2'b01) begin n_err++; $display("FAIL lf_c3_stalls got=%b exp=01", {d_stall, i_stall}); end
        n_cmp++; if (mem_rdata !== 32'h12345678) begin n_err++; $display("FAIL lf_c3_mem_rdata got=%h exp=12345678", mem_rdata); end
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24090001;
        #1;
        n_cmp++; if ({d_stall, i_stall} !== 2'b01) begin n_err++; $display("FAIL lf_c4_stalls got=%b exp=01", {d_stall, i_stall}); end
        next_cycle();
        bus_data_ok = 1'b0;
        #1;
        n_cmp++; if ({d_stall, i_stall} !== 2'b00) begin n_err++; $display("FAIL lf_c5_stalls got=%b exp=00", {d_stall, i_stall}); end
        n_cmp++; if (inst_rdata !== 32'h24090001 || mem_rdata !== 32'h12345678) begin n_err++; $display("FAIL lf_c5_bufs got=%h/%h exp=24090001/12345678", inst_rdata, mem_rdata); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_store_map();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] base;
            logic [31:0] wd;
            base = 32'h80000010 + 32'(i * 16);
            wd   = 32'h00AB0000 + 32'(i);
            next_cycle();
            mem_en = 1'b1; mem_rd = 1'b0; mem_wen = st_wen[i];
            mem_addr = base; mem_wdata = wd; all_stall = 1'b1;
            #1;
            n_cmp++; if (d_stall !== 1'b1) begin n_err++; $display("FAIL store%0d_pend got=%b exp=1", i, d_stall); end
            next_cycle();
            bus_addr_ok = 1'b1;
            #1;
            n_cmp++; if ({bus_req, bus_wr, bus_size} !== {2'b11, st_sz[i]}) begin n_err++; $display("FAIL store%0d_ctl got=%b%b%0d exp=11%0d", i, bus_req, bus_wr, bus_size, st_sz[i]); end
            n_cmp++; if (bus_addr !== {base[31:2], st_lo[i]}) begin n_err++; $display("FAIL store%0d_addr got=%h exp=%h", i, bus_addr, {base[31:2], st_lo[i]}); end
            n_cmp++; if (bus_wdata !== wd) begin n_err++; $display("FAIL store%0d_wdata got=%h exp=%h", i, bus_wdata, wd); end
            next_cycle();
            bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0;
            next_cycle();
            bus_data_ok = 1'b0;
            #1;
            n_cmp++; if (d_stall !== 1'b0) begin n_err++; $display("FAIL store%0d_done got=%b exp=0", i, d_stall); end
            idle_inputs();
            next_cycle();
        end
    endtask

    task automatic test_slow_bus_hold();
        next_cycle();
        mem_en = 1'b1; mem_rd = 1'b1; mem_wen = '0; mem_addr = 32'h80002000; all_stall = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            bus_addr_ok = (c == 4);
            #1;
            n_cmp++; if ({bus_req, bus_wr, bus_size, bus_addr} !== {2'b10, 2'd2, 32'h80002000}) begin n_err++; $display("FAIL slow_req_c%0d got=%b%b%0d %h exp=10 2 80002000", c, bus_req, bus_wr, bus_size, bus_addr); end
        end
        for (int c = 5; c <= 9; c++) begin
            next_cycle();
            bus_addr_ok = 1'b0;
            bus_data_ok = (c == 9);
            bus_rdata = (c == 9) ? 32'hAABBCCDD : 32'h0;
            #1;
            n_cmp++; if ({bus_req, d_stall} !== 2'b01) begin n_err++; $display("FAIL slow_wait_c%0d got=%b exp=01", c, {bus_req, d_stall}); end
        end
        for (int c = 10; c <= 13; c++) begin
            next_cycle();
            bus_data_ok = 1'b0; bus_rdata = 32'h0;
            #1;
            n_cmp++; if ({bus_req, d_stall, mem_rdata} !== {2'b00, 32'hAABBCCDD}) begin n_err++; $display("FAIL slow_hold_c%0d got=%b%b %h exp=00 aabbccdd", c, bus_req, d_stall, mem_rdata); end
        end
        next_cycle();
        all_stall = 1'b0;
        #1;
        n_cmp++; if ({d_stall, mem_rdata} !== {1'b0, 32'hAABBCCDD}) begin n_err++; $display("FAIL slow_c14 got=%b %h exp=0 aabbccdd", d_stall, mem_rdata); end
        // Next load arrives; it must be pending again because the done flag cleared.
        next_cycle();
        mem_addr = 32'h80002004; all_stall = 1'b1;
        #1;
        n_cmp++; if (d_stall !== 1'b1) begin n_err++; $display("FAIL slow_done_clear got=%b exp=1", d_stall); end
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0F0F0F0F;
        next_cycle();
        bus_data_ok = 1'b0;
        #1;
        n_cmp++; if ({d_stall, mem_rdata} !== {1'b0, 32'h0F0F0F0F}) begin n_err++; $display("FAIL slow_second got=%b %h exp=0 0f0f0f0f", d_stall, mem_rdata); end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        next_cycle();
        mem_en = 1'b1; mem_rd = 1'b1; mem_addr = 32'h80003000;
        inst_en = 1'b1; inst_addr = 32'hBFC00008; all_stall = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b1;
        next_cycle();
        bus_addr_ok = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== S_D_DATA) begin n_err++; $display("FAIL rstmid_pre got=%0d exp=%0d", dbg_state, S_D_DATA); end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== S_IDLE || bus_req !== 1'b0) begin n_err++; $display("FAIL rstmid_state got=%0d/%b exp=%0d/0", dbg_state, bus_req, S_IDLE); end
        n_cmp++; if ({d_stall, i_stall} !== 2'b11) begin n_err++; $display("FAIL rstmid_stalls got=%b exp=11", {d_stall, i_stall}); end
        n_cmp++; if (mem_rdata !== 32'h0 || inst_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_bufs got=%h/%h exp=0/0", mem_rdata, inst_rdata); end
        next_cycle();
        #1;
        n_cmp++; if (dbg_state !== S_D_ADDR || bus_req !== 1'b1) begin n_err++; $display("FAIL rstmid_restart got=%0d/%b exp=%0d/1", dbg_state, bus_req, S_D_ADDR); end
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_load_and_fetch();
        test_store_map();
        test_slow_bus_hold();
        test_reset_mid();
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
